// File: rtl/core_pkg.sv
// core_pkg: shared stage codes, RV32I opcode constants and small helpers
// used by the multicycle sequencer and its next-PC unit.
package core_pkg;

  // Stage code driven on the sequencer's state output.
  typedef logic [2:0] stage_t;

  localparam stage_t STATE_FETCH  = 3'd0;
  localparam stage_t STATE_DECODE = 3'd1;
  localparam stage_t STATE_EXEC   = 3'd2;
  localparam stage_t STATE_MEM    = 3'd3;
  localparam stage_t STATE_WRITE  = 3'd4;
  localparam stage_t STATE_HALT   = 3'd7;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Decoded control-transfer flags, bundled for the next-PC unit.
  typedef struct packed {
    logic branch_c;
    logic branch_uc;
    logic branch_relative;
  } branch_flags_t;

  // ecall/ebreak share the SYSTEM opcode; both stop the core cleanly.
  function automatic logic is_system(input logic [6:0] opcode);
    return opcode == OP_SYSTEM;
  endfunction

endpackage

// File: rtl/next_pc_unit.sv
// next_pc_unit: combinational next-PC selection for the WRITE stage.
// Picks between jump targets, taken-branch target and pc+4, and flags a
// target that is not word aligned. All arithmetic wraps modulo 2^32.
module next_pc_unit
  import core_pkg::*;
(
  input  logic [31:0]   pc,
  input  logic [31:0]   imm,
  input  logic [31:0]   alu_result,
  input  branch_flags_t flags,
  output logic [31:0]   next_pc,
  output logic          misaligned
);

  logic [31:0] seq_target;
  logic [31:0] rel_target;
  logic [31:0] reg_target;

  assign seq_target = pc + 32'd4;
  assign rel_target = pc + imm;
  // jalr clears bit 0 of the computed target before use.
  assign reg_target = alu_result & ~32'h1;

  // Unconditional jumps take priority, then a taken conditional branch.
  always_comb begin
    next_pc = seq_target;
    if (flags.branch_uc) begin
      next_pc = flags.branch_relative ? rel_target : reg_target;
    end else if (flags.branch_c && alu_result[0]) begin
      next_pc = rel_target;
    end
  end

  assign misaligned = next_pc[1:0] != 2'b00;

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WRITE control FSM for
// the single-issue RV32I core. Owns the PC, the instruction and data memory
// handshakes, the register write strobe and the halt/fault condition.
// Optional performance counters are built when CORE_SEQ_PERF_EN is defined;
// otherwise cycle_count and instret are tied to zero.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        branch_c,
  input  logic        branch_uc,
  input  logic        branch_relative,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        reg_we,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
);

  // The wait counter only needs to reach TIMEOUT_CYCLES-1 before the
  // threshold cycle, so size it to hold TIMEOUT_CYCLES.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic [31:0]       next_pc;
  logic              misaligned;
  branch_flags_t     flags;

  assign flags.branch_c        = branch_c;
  assign flags.branch_uc       = branch_uc;
  assign flags.branch_relative = branch_relative;

  next_pc_unit u_next_pc (
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .flags      (flags),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // A timeout value of zero means wait forever on memory.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  assign link_addr = pc + 32'd4;

  // The write strobe exists only in WRITE, even if the write is followed by
  // a misalignment halt.
  assign reg_we = (state == STATE_WRITE) && reg_write;

  // Main sequencing: stage transitions, handshakes, PC update, halt/fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_FETCH;
      pc        <= RESET_PC;
      instr_raw <= 32'h0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        STATE_FETCH: begin
          if (imem_req && imem_ack) begin
            instr_raw <= imem_rdata;
            imem_req  <= 1'b0;
            wait_cnt  <= '0;
            state     <= STATE_DECODE;
          end else if (timeout_hit) begin
            imem_req <= 1'b0;
            wait_cnt <= '0;
            halted   <= 1'b1;
            fault    <= 1'b1;
            state    <= STATE_HALT;
          end else begin
            imem_req <= 1'b1;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        STATE_DECODE: begin
          state <= STATE_EXEC;
        end

        STATE_EXEC: begin
          if (is_system(instr_raw[6:0])) begin
            halted <= 1'b1;
            state  <= STATE_HALT;
          end else if (mem_read || mem_write) begin
            dmem_req <= 1'b1;
            dmem_we  <= mem_write;
            wait_cnt <= '0;
            state    <= STATE_MEM;
          end else begin
            state <= STATE_WRITE;
          end
        end

        STATE_MEM: begin
          if (dmem_req && dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= '0;
            state    <= STATE_WRITE;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= '0;
            halted   <= 1'b1;
            fault    <= 1'b1;
            state    <= STATE_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        STATE_WRITE: begin
          wait_cnt <= '0;
          if (misaligned) begin
            halted <= 1'b1;
            fault  <= 1'b1;
            state  <= STATE_HALT;
          end else begin
            pc       <= next_pc;
            imem_req <= 1'b1;
            state    <= STATE_FETCH;
          end
        end

        STATE_HALT: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end

        default: begin
          // Unused stage codes can only come from corruption; stop hard.
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          halted   <= 1'b1;
          fault    <= 1'b1;
          state    <= STATE_HALT;
        end
      endcase
    end
  end

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // Free-running activity counters, frozen once the core halts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      if (!halted) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if ((state == STATE_WRITE) && !misaligned) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;
`else
  assign cycle_count = 32'h0;
  assign instret     = 32'h0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scoreboard bench for core_sequencer.
// Each instruction's expected per-cycle outputs are queued together with the
// memory-ack stimulus for that cycle, then popped and compared cycle by cycle.
module tb_core_sequencer;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC       = 32'h0000_0000;
  localparam int          TIMEOUT_CYCLES = 4;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_SYS   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_raw;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        branch_c = 1'b0;
  logic        branch_uc = 1'b0;
  logic        branch_relative = 1'b0;
  logic [31:0] imm = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        reg_we;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_count;
  logic [31:0] instret;

  core_sequencer #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .pc              (pc),
    .link_addr       (link_addr),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_raw       (instr_raw),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_ack        (dmem_ack),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .reg_write       (reg_write),
    .branch_c        (branch_c),
    .branch_uc       (branch_uc),
    .branch_relative (branch_relative),
    .imm             (imm),
    .alu_result      (alu_result),
    .reg_we          (reg_we),
    .halted          (halted),
    .fault           (fault),
    .cycle_count     (cycle_count),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iack;
    logic [31:0] rdata;
    logic        dack;
    logic [2:0]  st;
    logic [31:0] pc;
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic        rwe;
    logic        hlt;
    logic        flt;
    logic        chk_ir;
    logic [31:0] ir;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    step = 0;
  int    exp_cycles = 0;
  int    exp_retired = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s@%0d observed=%h expected=%h", tag, step, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic rw,
                               input logic bc, input logic buc, input logic brel,
                               input logic [31:0] im, input logic [31:0] al);
    mem_read        = rd;
    mem_write       = wr;
    reg_write       = rw;
    branch_c        = bc;
    branch_uc       = buc;
    branch_relative = brel;
    imm             = im;
    alu_result      = al;
  endtask

  // Reference next-PC rule, written from the architectural definition.
  function automatic logic [31:0] modelNextPc(input logic [31:0] p);
    if (branch_uc) begin
      if (branch_relative) return p + imm;
      return {alu_result[31:1], 1'b0};
    end
    if (branch_c && alu_result[0]) return p + imm;
    return p + 32'd4;
  endfunction

  task automatic pushItem(input logic ia, input logic [31:0] rd, input logic da,
                          input logic [2:0] st, input logic [31:0] p,
                          input logic ireq, input logic dreq, input logic dwe,
                          input logic rwe, input logic hlt, input logic flt,
                          input logic ci, input logic [31:0] ir);
    item_t it;
    it.iack = ia;  it.rdata = rd;  it.dack = da;  it.st = st;  it.pc = p;
    it.ireq = ireq; it.dreq = dreq; it.dwe = dwe; it.rwe = rwe;
    it.hlt = hlt;  it.flt = flt;  it.chk_ir = ci; it.ir = ir;
    sb_q.push_back(it);
  endtask

  // Queue one instruction's life. idle: first fetch cycle after reset with
  // the request still low; iwait/dwait: request cycles without an ack.
  task automatic queueInstr(input logic [31:0] instr, input logic [31:0] p,
                            input bit idle, input logic idle_ack, input int iwait,
                            input int kind, input int dwait);
    logic [31:0] np;
    logic        st_we;
    np = modelNextPc(p);
    st_we = (kind == K_STORE);
    if (idle) pushItem(idle_ack, instr, 1'b0, STATE_FETCH, p, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < iwait; i++)
      pushItem(1'b0, 32'hDEAD_BEEF, 1'b0, STATE_FETCH, p, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    pushItem(1'b1, instr, 1'b0, STATE_FETCH, p, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    pushItem(1'b0, 32'h0, 1'b0, STATE_DECODE, p, 0, 0, 0, 0, 0, 0, 1, instr);
    pushItem(1'b0, 32'h0, 1'b0, STATE_EXEC, p, 0, 0, 0, 0, 0, 0, 1, instr);
    if (kind == K_SYS) begin
      pushItem(1'b0, 32'h0, 1'b0, STATE_HALT, p, 0, 0, 0, 0, 1, 0, 1, instr);
      return;
    end
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int i = 0; i < dwait; i++)
        pushItem(1'b0, 32'h0, 1'b0, STATE_MEM, p, 0, 1, st_we, 0, 0, 0, 1, instr);
      pushItem(1'b0, 32'h0, 1'b1, STATE_MEM, p, 0, 1, st_we, 0, 0, 0, 1, instr);
    end
    pushItem(1'b0, 32'h0, 1'b0, STATE_WRITE, p, 0, 0, 0, reg_write, 0, 0, 1, instr);
    if (np[1:0] != 2'b00)
      pushItem(1'b0, 32'h0, 1'b0, STATE_HALT, p, 0, 0, 0, 0, 1, 1, 1, instr);
    else
      exp_retired++;
  endtask

  task automatic runQueue;
    item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      imem_ack   = it.iack;
      imem_rdata = it.rdata;
      dmem_ack   = it.dack;
      checkOutput("state", {29'h0, state}, {29'h0, it.st});
      checkOutput("pc", pc, it.pc);
      checkOutput("link_addr", link_addr, it.pc + 32'd4);
      checkOutput("imem_req", {31'h0, imem_req}, {31'h0, it.ireq});
      checkOutput("dmem_req", {31'h0, dmem_req}, {31'h0, it.dreq});
      checkOutput("dmem_we", {31'h0, dmem_we}, {31'h0, it.dwe});
      checkOutput("reg_we", {31'h0, reg_we}, {31'h0, it.rwe});
      checkOutput("halted", {31'h0, halted}, {31'h0, it.hlt});
      checkOutput("fault", {31'h0, fault}, {31'h0, it.flt});
      if (it.chk_ir) checkOutput("instr_raw", instr_raw, it.ir);
      if (!it.hlt) exp_cycles++;
      step++;
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic resetDut;
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    checkOutput("rst_state", {29'h0, state}, {29'h0, STATE_FETCH});
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_instr_raw", instr_raw, 32'h0);
    checkOutput("rst_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted}, 32'h0);
    checkOutput("rst_fault", {31'h0, fault}, 32'h0);
    rst = 1'b0;
    exp_cycles = 0;
    exp_retired = 0;
  endtask

  task automatic checkPerf;
`ifdef CORE_SEQ_PERF_EN
    checkOutput("cycle_count", cycle_count, 32'(exp_cycles));
    checkOutput("instret", instret, 32'(exp_retired));
`else
    checkOutput("cycle_count", cycle_count, 32'h0);
    checkOutput("instret", instret, 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    $display("[TB] core_sequencer bench start");
    resetDut();

    // addi x1,x0,5: fetch ack on the 4th FETCH cycle, pc 0 -> 4.
    applyStimulus(0, 0, 1, 0, 0, 0, 32'd5, 32'd5);
    queueInstr(32'h0050_0093, 32'h0, 1, 1'b0, 2, K_ALU, 0);
    runQueue();

    // sw: three MEM cycles, store request, no register write.
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0, 32'h40);
    queueInstr(32'h0020_a023, 32'h4, 0, 1'b0, 0, K_STORE, 2);
    runQueue();

    // jal +8 to reach 0x10.
    applyStimulus(0, 0, 1, 0, 1, 1, 32'd8, 32'h0);
    queueInstr(32'h0080_00ef, 32'h8, 0, 1'b0, 0, K_ALU, 0);
    runQueue();

    // beq taken at 0x10, imm 0x20 -> 0x30.
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h20, 32'h1);
    queueInstr(32'h0200_0063, 32'h10, 0, 1'b0, 0, K_ALU, 0);
    runQueue();

    // jal -0x20 back to 0x10.
    applyStimulus(0, 0, 1, 0, 1, 1, 32'hFFFF_FFE0, 32'h0);
    queueInstr(32'hfe1f_f0ef, 32'h30, 0, 1'b0, 0, K_ALU, 0);
    runQueue();

    // beq not taken at 0x10 -> 0x14.
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h20, 32'h0);
    queueInstr(32'h0200_0063, 32'h10, 0, 1'b0, 0, K_ALU, 0);
    runQueue();

    // lw with one fetch wait and an immediate data ack.
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h8, 32'h48);
    queueInstr(32'h0080_a103, 32'h14, 0, 1'b0, 1, K_LOAD, 0);
    runQueue();

    // jalr to 0x101 -> 0x100; link_addr checked as 0x1C during WRITE.
    applyStimulus(0, 0, 1, 0, 1, 0, 32'h0, 32'h101);
    queueInstr(32'h0000_80e7, 32'h18, 0, 1'b0, 0, K_ALU, 0);
    runQueue();

    // jalr to 0x102: strobe still pulses, then fault halt with pc frozen;
    // acks offered while halted must be ignored.
    applyStimulus(0, 0, 1, 0, 1, 0, 32'h0, 32'h102);
    queueInstr(32'h0000_80e7, 32'h100, 0, 1'b0, 0, K_ALU, 0);
    pushItem(1'b1, 32'h0050_0093, 1'b1, STATE_HALT, 32'h100, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    pushItem(1'b1, 32'h0050_0093, 1'b1, STATE_HALT, 32'h100, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    runQueue();
    checkPerf();

    // Fetch timeout: no ack for four cycles -> fault halt, request dropped.
    resetDut();
    pushItem(1'b0, 32'h0, 1'b0, STATE_FETCH, RESET_PC, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      pushItem(1'b0, 32'h0, 1'b0, STATE_FETCH, RESET_PC, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    pushItem(1'b1, 32'h0, 1'b0, STATE_HALT, RESET_PC, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    pushItem(1'b0, 32'h0, 1'b0, STATE_HALT, RESET_PC, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    runQueue();
    checkPerf();

    // After reset: an ack while the request is still low is ignored; then
    // pc wraps through 0xFFFF_FFFC and ebreak stops without fault.
    resetDut();
    applyStimulus(0, 0, 1, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    queueInstr(32'hffdf_f0ef, RESET_PC, 1, 1'b1, 0, K_ALU, 0);
    runQueue();
    applyStimulus(0, 0, 1, 0, 0, 0, 32'd5, 32'd5);
    queueInstr(32'h0050_0093, 32'hFFFF_FFFC, 0, 1'b0, 0, K_ALU, 0);
    runQueue();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    queueInstr(32'h0010_0073, 32'h0, 0, 1'b0, 0, K_SYS, 0);
    pushItem(1'b1, 32'h0, 1'b1, STATE_HALT, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    runQueue();
    checkPerf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multicycle control FSM for the single-issue RV32I core.
- Produces the 3-bit `state` that gates the decode stage and the other stages: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=7.
- Owns the PC, the instruction/data memory req/ack handshakes, next-PC selection, the register write-enable pulse, and the halt/fault condition.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting on any memory ack before fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- state  out  3  current stage code
- pc  out  32  address of the current instruction
- link_addr  out  32  pc+4, write-back data for jal/jalr
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched word
- instr_raw  out  32  latched instruction, fed to decode
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a store
- dmem_ack  in  1  data access complete
- mem_read  in  1  decoded load flag
- mem_write  in  1  decoded store flag
- reg_write  in  1  decoded register-write flag
- branch_c  in  1  decoded conditional-branch flag
- branch_uc  in  1  decoded unconditional-jump flag
- branch_relative  in  1  decoded relative-target flag
- imm  in  32  decoded immediate
- alu_result  in  32  ALU output; bit0 is the branch condition
- reg_we  out  1  register-file write strobe
- halted  out  1  core stopped
- fault  out  1  stop caused by error
- cycle_count  out  32  see Optional Feature
- instret  out  32  see Optional Feature

Behaviour:
- Reset values (synchronous on rst=1): state=FETCH, pc=RESET_PC, instr_raw=0, imem_req=0, dmem_req=0, dmem_we=0, reg_we=0, halted=0, fault=0, wait counter=0.
- rst asserted mid-transaction: all outputs return to reset values on the same edge. A late ack after reset is ignored unless state is FETCH and imem_req=1.
- FETCH: imem_req=1, held until imem_ack.
  - On an ack cycle: instr_raw<=imem_rdata, imem_req<=0, state<=DECODE.
  - Minimum FETCH length is 1 cycle (ack returned combinationally).
- DECODE: exactly 1 cycle, then state<=EXEC. Decode flags are valid from EXEC onward.
- EXEC: 1 cycle; decision is made on instr_raw[6:0] and the decode flags.
  - instr_raw[6:0]==7'b1110011 (ecall/ebreak): state<=HALT, halted=1, fault=0.
  - else mem_read or mem_write: state<=MEM.
  - else: state<=WRITE.
- MEM: dmem_req=1, dmem_we=mem_write, both held until dmem_ack. Then dmem_req<=0, dmem_we<=0, state<=WRITE.
- Wait counter: increments each cycle spent in FETCH or MEM without an ack; cleared on ack or on state change.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: state<=HALT, halted=1, fault=1, request dropped.
- WRITE: 1 cycle. reg_we=reg_write for this single cycle only; reg_we=0 in every other state.
- Next PC, computed in WRITE:
  - branch_uc & branch_relative: pc+imm
  - branch_uc & !branch_relative: alu_result & ~32'h1
  - branch_c & alu_result[0]: pc+imm
  - otherwise: pc+4
- All PC arithmetic is 32-bit and wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0, no fault.
- Misalignment check in WRITE: if next_pc[1:0]!=0, then pc is unchanged, state<=HALT, fault=1, reg_we is still issued this cycle. Otherwise pc<=next_pc and state<=FETCH.
- HALT: sticky until rst; no requests, reg_we=0, pc frozen.
- link_addr = pc+4, combinational from the registered pc.
- Simultaneous ack and timeout threshold in the same cycle: the ack wins.

Optional Feature:
- Macro CORE_SEQ_PERF_EN.
- Defined:
  - cycle_count increments every non-reset cycle while not halted.
  - instret increments on each WRITE cycle that leaves for FETCH.
  - Both are 32-bit wrapping, cleared on rst, and frozen in HALT.
- Undefined: both ports driven constant 0 and no counter registers exist.

Decomposition:
- Shared package core_pkg holds:
  - stage localparams STATE_FETCH..STATE_WRITE, STATE_HALT=3'd7
  - opcode constants OP_SYSTEM=7'b1110011 and the other opcodes (OP_BRANCH, OP_JAL, OP_JALR, ...)
- Sub-module next_pc_unit: combinational; inputs pc, imm, alu_result and the branch flags; outputs next_pc and misaligned.

Test Plan:
- addi x1,x0,5 with imem_ack delayed 3 cycles → state sequence 0,0,0,0,1,2,4,0; reg_we high exactly one cycle; pc 0→4.
- sw with dmem_ack delayed 2 cycles → MEM for 3 cycles with dmem_req=1, dmem_we=1; then WRITE with reg_we=0; pc+=4.
- beq at pc=0x10, imm=0x20:
  - alu_result=1 → pc=0x30
  - alu_result=0 → pc=0x14
- jalr with alu_result=0x101 → pc=0x100 and link_addr=pc_old+4 during WRITE.
- jalr with alu_result=0x102 → reg_we pulses, then HALT with fault=1, pc unchanged.
- TIMEOUT_CYCLES=4, imem_ack never asserted → HALT with fault=1 after 4 wait cycles, imem_req deasserted. Then:
  - rst → FETCH, pc=RESET_PC.
  - ebreak → HALT with fault=0.
